// File: rtl/iic_cfg_sequencer.sv
// OV7670 configuration sequencer: walks the register LUT, issues each entry
// as one I2C write with NACK retry and inter-write gaps, then serves host writes.
module iic_cfg_sequencer #(
   parameter int unsigned LUT_START  = 2,
   parameter int unsigned LUT_LAST   = 166,
   parameter logic [7:0]  SLAVE_ADDR = 8'h42,
   parameter int unsigned MAX_RETRY  = 3,
   parameter int unsigned GAP_CYCLES = 16,
   parameter int unsigned RST_DELAY  = 4096,
   parameter int unsigned AUTO_START = 1
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   input  logic        start,
   output logic [7:0]  LUT_INDEX,
   input  logic [15:0] LUT_DATA,
   output logic        wr_req,
   output logic [7:0]  wr_addr,
   output logic [15:0] wr_data,
   input  logic        wr_done,
   input  logic        wr_nack,
   input  logic        host_req,
   input  logic [15:0] host_data,
   output logic        host_ack,
   output logic        host_err,
   output logic        cfg_busy,
   output logic        cfg_done,
   output logic        cfg_err
);

   localparam int unsigned GAP_MAX = (RST_DELAY > GAP_CYCLES) ? RST_DELAY : GAP_CYCLES;
   localparam int unsigned GAP_W   = $clog2(GAP_MAX + 1);
   localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_GAP, S_READY, S_HOST, S_ERROR
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [7:0]         r_idx, w_idx;
   logic               r_wr_req, w_wr_req;
   logic [15:0]        r_wr_data, w_wr_data;
   logic [GAP_W-1:0]   r_gap_cnt, w_gap_cnt;
   logic [RETRY_W-1:0] r_retry, w_retry;
   logic               r_host, w_host;
   logic               r_to_issue, w_to_issue;
   logic               r_auto, w_auto;
   logic               r_host_ack, w_host_ack;
   logic               r_host_err, w_host_err;
   logic               r_busy, w_busy;
   logic               r_done, w_done;
   logic               r_err, w_err;

   logic               w_can_retry;
   logic               w_is_last;
   logic               w_is_soft_rst;
   logic               w_restart;

   assign w_can_retry   = (32'(r_retry) < MAX_RETRY);
   assign w_is_last     = (r_idx == 8'(LUT_LAST));
   assign w_is_soft_rst = (r_wr_data[15:8] == 8'h12) && r_wr_data[7];

   // State register
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next-state decode; a simultaneous done+nack is handled as a NACK
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start || r_auto) w_state_nxt = S_FETCH;
         S_FETCH: w_state_nxt = S_ISSUE;
         S_ISSUE: w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (wr_nack) begin
               w_state_nxt = (w_can_retry || r_host) ? S_GAP : S_ERROR;
            end else if (wr_done) begin
               w_state_nxt = (!r_host && w_is_last) ? S_READY : S_GAP;
            end
         end
         S_GAP: begin
            if (r_gap_cnt == '0) begin
               if (r_to_issue)  w_state_nxt = S_ISSUE;
               else if (r_host) w_state_nxt = S_READY;
               else             w_state_nxt = S_FETCH;
            end
         end
         S_READY: begin
            if (start)         w_state_nxt = S_FETCH;
            else if (host_req) w_state_nxt = S_HOST;
         end
         S_HOST:  w_state_nxt = S_ISSUE;
         S_ERROR: if (start) w_state_nxt = S_FETCH;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Next values of the datapath and registered outputs
   always_comb begin
      w_idx      = r_idx;
      w_wr_data  = r_wr_data;
      w_gap_cnt  = r_gap_cnt;
      w_retry    = r_retry;
      w_host     = r_host;
      w_to_issue = r_to_issue;
      w_auto     = r_auto;
      w_host_ack = 1'b0;
      w_host_err = 1'b0;
      w_busy     = r_busy;
      w_done     = r_done;
      w_err      = r_err;
      w_wr_req   = (w_state_nxt == S_ISSUE) || (w_state_nxt == S_WAIT);

      w_restart = (w_state_nxt == S_FETCH) &&
                  ((r_state == S_IDLE) || (r_state == S_READY) || (r_state == S_ERROR));
      if (w_restart) begin
         w_idx  = 8'(LUT_START);
         w_busy = 1'b1;
         w_done = 1'b0;
         w_err  = 1'b0;
         w_auto = 1'b0;
         w_host = 1'b0;
      end

      case (r_state)
         S_FETCH: begin
            w_wr_data  = LUT_DATA;
            w_retry    = '0;
            w_to_issue = 1'b0;
         end
         S_READY: begin
            if (w_state_nxt == S_HOST) begin
               w_wr_data = host_data;
               w_host    = 1'b1;
            end
         end
         S_HOST: begin
            w_retry    = '0;
            w_to_issue = 1'b0;
         end
         S_WAIT: begin
            if (wr_nack) begin
               if (w_can_retry) begin
                  w_retry    = r_retry + RETRY_W'(1);
                  w_gap_cnt  = GAP_W'(GAP_CYCLES);
                  w_to_issue = 1'b1;
               end else if (r_host) begin
                  w_host_ack = 1'b1;
                  w_host_err = 1'b1;
                  w_gap_cnt  = GAP_W'(GAP_CYCLES);
                  w_to_issue = 1'b0;
               end else begin
                  w_err  = 1'b1;
                  w_busy = 1'b0;
               end
            end else if (wr_done) begin
               w_to_issue = 1'b0;
               if (r_host) begin
                  w_host_ack = 1'b1;
                  w_gap_cnt  = GAP_W'(GAP_CYCLES);
               end else if (w_is_last) begin
                  w_done = 1'b1;
                  w_busy = 1'b0;
               end else begin
                  w_idx     = r_idx + 8'd1;
                  w_gap_cnt = w_is_soft_rst ? GAP_W'(RST_DELAY) : GAP_W'(GAP_CYCLES);
               end
            end
         end
         S_GAP: begin
            if (r_gap_cnt != '0)              w_gap_cnt = r_gap_cnt - GAP_W'(1);
            else if (w_state_nxt == S_READY) w_host    = 1'b0;
         end
         default: ;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_idx      <= 8'(LUT_START);
         r_wr_req   <= 1'b0;
         r_wr_data  <= '0;
         r_gap_cnt  <= '0;
         r_retry    <= '0;
         r_host     <= 1'b0;
         r_to_issue <= 1'b0;
         r_auto     <= 1'(AUTO_START != 0);
         r_host_ack <= 1'b0;
         r_host_err <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_idx      <= w_idx;
         r_wr_req   <= w_wr_req;
         r_wr_data  <= w_wr_data;
         r_gap_cnt  <= w_gap_cnt;
         r_retry    <= w_retry;
         r_host     <= w_host;
         r_to_issue <= w_to_issue;
         r_auto     <= w_auto;
         r_host_ack <= w_host_ack;
         r_host_err <= w_host_err;
         r_busy     <= w_busy;
         r_done     <= w_done;
         r_err      <= w_err;
      end
   end

   assign LUT_INDEX = r_idx;
   assign wr_req    = r_wr_req;
   assign wr_addr   = SLAVE_ADDR;
   assign wr_data   = r_wr_data;
   assign host_ack  = r_host_ack;
   assign host_err  = r_host_err;
   assign cfg_busy  = r_busy;
   assign cfg_done  = r_done;
   assign cfg_err   = r_err;

endmodule

// File: tb/tb_iic_cfg_sequencer.sv
// Scoreboard bench for iic_cfg_sequencer: expected writes/acks are queued by the
// stimulus and consumed by a monitor; a scripted slave ACKs or NACKs writes.
`timescale 1ns/1ps
module tb_iic_cfg_sequencer;

   localparam int unsigned GAP = 4;
   localparam int unsigned RSTD = 40;

   logic        iCLK = 1'b0;
   logic        iRST_N = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  LUT_INDEX;
   logic [15:0] LUT_DATA;
   logic        wr_req;
   logic [7:0]  wr_addr;
   logic [15:0] wr_data;
   logic        wr_done = 1'b0;
   logic        wr_nack = 1'b0;
   logic        host_req = 1'b0;
   logic [15:0] host_data = 16'h0000;
   logic        host_ack;
   logic        host_err;
   logic        cfg_busy;
   logic        cfg_done;
   logic        cfg_err;

   logic [15:0] lut [0:255];
   assign LUT_DATA = lut[LUT_INDEX];

   logic [15:0] exp_wr[$];
   logic        exp_ack[$];
   int          idle_log[$];

   int          n_tests = 0;
   int          n_fail  = 0;

   logic [15:0] nack_data = 16'h0000;
   int          nack_left = 0;
   bit          slave_hold = 1'b0;

   iic_cfg_sequencer #(
      .LUT_START(2), .LUT_LAST(4), .SLAVE_ADDR(8'h42), .MAX_RETRY(3),
      .GAP_CYCLES(GAP), .RST_DELAY(RSTD), .AUTO_START(1)
   ) dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .start(start), .LUT_INDEX(LUT_INDEX),
      .LUT_DATA(LUT_DATA), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_done(wr_done), .wr_nack(wr_nack), .host_req(host_req), .host_data(host_data),
      .host_ack(host_ack), .host_err(host_err), .cfg_busy(cfg_busy),
      .cfg_done(cfg_done), .cfg_err(cfg_err)
   );

   always #5 iCLK = ~iCLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout", name);
   endtask

   // Slave: responds two cycles after seeing a request, ACK unless scripted NACK
   initial begin
      forever begin
         @(posedge iCLK); #1;
         if (wr_req && !slave_hold) begin
            repeat (2) begin @(posedge iCLK); #1; end
            if (wr_req) begin
               if (wr_data == nack_data && nack_left != 0) begin
                  wr_nack = 1'b1;
                  if (nack_left > 0) nack_left--;
               end else begin
                  wr_done = 1'b1;
               end
               @(posedge iCLK); #1;
               wr_done = 1'b0;
               wr_nack = 1'b0;
            end
         end
      end
   end

   // Monitor: checks each new write request and each host_ack against the queues
   initial begin
      logic        prev;
      int          idle;
      logic [15:0] e;
      logic        ea;
      prev = 1'b0;
      idle = 0;
      forever begin
         @(posedge iCLK); #1;
         if (wr_req && !prev) begin
            idle_log.push_back(idle);
            idle = 0;
            if (exp_wr.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_wr_req: got %h expected none", wr_data);
            end else begin
               e = exp_wr.pop_front();
               check("wr_data", 32'(wr_data), 32'(e));
               check("wr_addr", 32'(wr_addr), 32'h42);
            end
         end else if (!wr_req) begin
            idle++;
         end
         prev = wr_req;
         if (host_ack) begin
            if (exp_ack.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_host_ack: got err=%0d expected none", host_err);
            end else begin
               ea = exp_ack.pop_front();
               check("host_err", 32'(host_err), 32'(ea));
               check("ack_busy", 32'(cfg_busy), 32'h0);
            end
         end
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge iCLK);
      #1;
   endtask

   task automatic pulse_start(input bit with_host, input logic [15:0] hd);
      @(posedge iCLK); #1;
      start = 1'b1;
      if (with_host) begin
         host_req  = 1'b1;
         host_data = hd;
      end
      @(posedge iCLK); #1;
      start = 1'b0;
   endtask

   // Wait for a configuration run to begin and end
   task automatic wait_busy(input string name);
      bit seen;
      int n;
      seen = cfg_busy;
      n = 0;
      while (n < 3000 && !(seen && !cfg_busy)) begin
         @(posedge iCLK); #1;
         if (cfg_busy) seen = 1'b1;
         n++;
      end
      if (n >= 3000) fail_now(name);
   endtask

   task automatic wait_ack(input string name);
      int n;
      n = 0;
      while (n < 500 && !host_ack) begin
         @(posedge iCLK); #1;
         n++;
      end
      if (!host_ack) fail_now(name);
      host_req = 1'b0;
   endtask

   function automatic int idle_at(input int i);
      if (i < idle_log.size()) return idle_log[i];
      return -1;
   endfunction

   task automatic load_base_lut();
      lut[2] = 16'h1214;
      lut[3] = 16'h40d0;
      lut[4] = 16'h3a04;
   endtask

   task automatic push3();
      exp_wr.push_back(16'h1214);
      exp_wr.push_back(16'h40d0);
      exp_wr.push_back(16'h3a04);
   endtask

   task automatic check_drained(input string name);
      check({name, "_wr_q"}, 32'(exp_wr.size()), 32'h0);
      check({name, "_ack_q"}, 32'(exp_ack.size()), 32'h0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) lut[i] = 16'h0000;
      load_base_lut();

      // Reset values; a host request is already pending during configuration
      host_req  = 1'b1;
      host_data = 16'h3b42;
      push3();
      exp_wr.push_back(16'h3b42);
      exp_ack.push_back(1'b0);
      #12;
      check("rst_wr_req",  32'(wr_req), 32'h0);
      check("rst_wr_data", 32'(wr_data), 32'h0);
      check("rst_index",   32'(LUT_INDEX), 32'h2);
      check("rst_busy",    32'(cfg_busy), 32'h0);
      check("rst_done",    32'(cfg_done), 32'h0);
      check("rst_err",     32'(cfg_err), 32'h0);
      check("rst_wr_addr", 32'(wr_addr), 32'h42);
      @(negedge iCLK);
      iRST_N = 1'b1;

      // Plain configuration, host write deferred until configuration completes
      wait_busy("cfg1_timeout");
      check("cfg1_done",  32'(cfg_done), 32'h1);
      check("cfg1_busy",  32'(cfg_busy), 32'h0);
      check("cfg1_err",   32'(cfg_err), 32'h0);
      check("cfg1_index", 32'(LUT_INDEX), 32'h4);
      check("cfg1_gap1",  32'(idle_at(1)), 32'(GAP + 2));
      check("cfg1_gap2",  32'(idle_at(2)), 32'(GAP + 2));
      wait_ack("host1_timeout");
      wait_cycles(GAP + 4);
      check_drained("cfg1");

      // Soft-reset entry gets the long delay
      lut[2] = 16'h1280;
      lut[3] = 16'h1100;
      idle_log.delete();
      exp_wr.push_back(16'h1280);
      exp_wr.push_back(16'h1100);
      exp_wr.push_back(16'h3a04);
      pulse_start(1'b0, 16'h0000);
      wait_busy("cfg2_timeout");
      check("cfg2_rstgap", 32'(idle_at(1)), 32'(RSTD + 2));
      check("cfg2_gap",    32'(idle_at(2)), 32'(GAP + 2));
      check("cfg2_done",   32'(cfg_done), 32'h1);
      check_drained("cfg2");

      // Entry 3 NACKed twice, then ACKed
      load_base_lut();
      nack_data = 16'h40d0;
      nack_left = 2;
      idle_log.delete();
      exp_wr.push_back(16'h1214);
      repeat (3) exp_wr.push_back(16'h40d0);
      exp_wr.push_back(16'h3a04);
      pulse_start(1'b0, 16'h0000);
      wait_busy("cfg3_timeout");
      check("cfg3_retry_gap", 32'(idle_at(2)), 32'(GAP + 1));
      check("cfg3_next_gap",  32'(idle_at(4)), 32'(GAP + 2));
      check("cfg3_err",       32'(cfg_err), 32'h0);
      check("cfg3_done",      32'(cfg_done), 32'h1);
      check("cfg3_index",     32'(LUT_INDEX), 32'h4);
      check_drained("cfg3");

      // Entry 2 always NACKed: four attempts then error
      nack_data = 16'h1214;
      nack_left = -1;
      repeat (4) exp_wr.push_back(16'h1214);
      pulse_start(1'b0, 16'h0000);
      wait_busy("cfg4_timeout");
      wait_cycles(40);
      check("cfg4_err",   32'(cfg_err), 32'h1);
      check("cfg4_done",  32'(cfg_done), 32'h0);
      check("cfg4_busy",  32'(cfg_busy), 32'h0);
      check("cfg4_index", 32'(LUT_INDEX), 32'h2);
      check_drained("cfg4");

      // Recover from ERROR, then a host write that exhausts its retries
      nack_left = 0;
      push3();
      pulse_start(1'b0, 16'h0000);
      wait_busy("cfg5_timeout");
      check("cfg5_err_cleared", 32'(cfg_err), 32'h0);
      nack_data = 16'h5555;
      nack_left = -1;
      repeat (4) exp_wr.push_back(16'h5555);
      exp_ack.push_back(1'b1);
      host_data = 16'h5555;
      host_req  = 1'b1;
      wait_ack("host5_timeout");
      wait_cycles(GAP + 4);
      check("host5_cfg_err",  32'(cfg_err), 32'h0);
      check("host5_cfg_done", 32'(cfg_done), 32'h1);
      check_drained("host5");
      nack_left = 0;

      // start and host_req together in READY: configuration reruns first
      push3();
      exp_wr.push_back(16'h3b42);
      exp_ack.push_back(1'b0);
      pulse_start(1'b1, 16'h3b42);
      wait_busy("cfg6_timeout");
      wait_ack("host6_timeout");
      wait_cycles(GAP + 4);
      check_drained("cfg6");

      // Reset while a write is outstanding
      slave_hold = 1'b1;
      exp_wr.push_back(16'h1214);
      pulse_start(1'b0, 16'h0000);
      begin
         int n;
         n = 0;
         while (n < 50 && !wr_req) begin @(posedge iCLK); #1; n++; end
         if (!wr_req) fail_now("cfg7_req_timeout");
      end
      wait_cycles(3);
      check("cfg7_req_before", 32'(wr_req), 32'h1);
      #1;
      iRST_N = 1'b0;
      #1;
      check("cfg7_req_async", 32'(wr_req), 32'h0);
      check("cfg7_busy_rst",  32'(cfg_busy), 32'h0);
      push3();
      @(negedge iCLK);
      iRST_N = 1'b1;
      slave_hold = 1'b0;
      wait_busy("cfg7_timeout");
      check("cfg7_done", 32'(cfg_done), 32'h1);
      wait_cycles(GAP + 4);
      check_drained("cfg7");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global bound on run time
   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
